// File: rtl/prog_clock_divider_pkg.sv
// Shared constants, channel state type and divisor helpers for the programmable clock divider.
package clkdiv_pkg;
  localparam int DIV_MIN = 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  // Number of clk cycles q_p stays high in one period of divisor n.
  function automatic int unsigned half_of(input int unsigned n);
    return (n + 1) >> 1;
  endfunction
endpackage

// File: rtl/prog_clock_divider_if.sv
// Divisor reload port: valid/ready write of a divisor to one channel, plus sticky error flag.
interface prog_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: period counter, run/idle state, pending divisor and 50%-duty output.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend,
  output logic             div_clk,
  output logic             tick
);
  ch_state_t        state;
  logic [DIV_W-1:0] cnt, div_cur, pend_div;
  logic [DIV_W:0]   half, cnt_nx;
  logic             q_p, q_n, bnd;

  assign half   = (DIV_W+1)'(half_of(32'(div_cur)));
  assign cnt_nx = {1'b0, cnt} + {{DIV_W{1'b0}}, 1'b1};
  assign tick   = (state == RUN) && (cnt == div_cur - DIV_W'(1));
  // Divisor may only change while stopped or on the last cycle of a period.
  assign bnd    = (state == IDLE) || tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      q_p      <= 1'b0;
      div_cur  <= DIV_W'(DEF_DIV);
      pend_div <= DIV_W'(DEF_DIV);
      pend     <= 1'b0;
    end else begin
      if (bnd && pend) begin
        div_cur <= pend_div;
        pend    <= 1'b0;
      end
      // Writes are only accepted with pend clear, so this never overwrites an unconsumed divisor.
      if (wr) begin
        pend_div <= wr_div;
        pend     <= 1'b1;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          q_p <= en;
          if (en) state <= RUN;
        end
        RUN: begin
          if (tick) begin
            cnt <= '0;
            q_p <= en;
            if (!en) state <= IDLE;
          end else begin
            cnt <= cnt_nx[DIV_W-1:0];
            q_p <= (cnt_nx < half);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Half-cycle delayed copy; ANDing it in trims odd-N high time to exactly N/2 cycles.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) q_n <= 1'b0;
    else     q_n <= q_p;
  end

  assign div_clk = div_cur[0] ? (q_p & q_n) : q_p;
endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: cfg decode, ready mux and sticky error; channels do the rest.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   en,
  prog_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]   div_clk,
  output logic [NUM_CH-1:0]   tick
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]      pend, wr;
  logic [(1<<CH_W)-1:0]   pend_ext;
  logic                   acc, legal;

  // Non-existent channels read as ready so an out-of-range write is accepted and flagged.
  always_comb begin
    pend_ext             = '0;
    pend_ext[NUM_CH-1:0] = pend;
  end

  assign cfg.cfg_ready = ~pend_ext[cfg.cfg_ch];
  assign acc           = cfg.cfg_valid & cfg.cfg_ready;
  assign legal         = (32'(cfg.cfg_ch) < NUM_CH) && (cfg.cfg_div >= DIV_W'(DIV_MIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cfg.cfg_err <= 1'b0;
    else if (acc && !legal) cfg.cfg_err <= 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = acc & legal & (cfg.cfg_ch == CH_W'(i));

    clkdiv_channel #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .wr      (wr[i]),
      .wr_div  (cfg.cfg_div),
      .pend    (pend[i]),
      .div_clk (div_clk[i]),
      .tick    (tick[i])
    );
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomized bench for prog_clock_divider against a half-cycle period-schedule reference model.
module tb_prog_clock_divider;
  localparam int NUM_CH  = 4;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 2;

  logic              clk = 1'b1;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] en  = '1;
  logic [NUM_CH-1:0] div_clk, tick;

  prog_clock_divider_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg ();

  prog_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg),
    .div_clk (div_clk),
    .tick    (tick)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each channel is either stopped or somewhere in a period of m_n clk cycles,
  // tracked as a half-cycle position m_pos counted from the period's starting posedge.
  bit m_run  [NUM_CH];
  int m_pos  [NUM_CH];
  int m_n    [NUM_CH];
  bit m_pend [NUM_CH];
  int m_pd   [NUM_CH];
  bit m_err;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_n[c] = DEF_DIV; m_pend[c] = 0; m_pd[c] = DEF_DIV;
    end
    m_err = 0;
  endfunction

  function automatic bit m_ready(input int ch);
    return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
  endfunction

  function automatic bit exp_clk(input int c);
    if (!m_run[c]) return 1'b0;
    if (m_n[c] % 2 == 1) return (m_pos[c] >= 1) && (m_pos[c] <= m_n[c]);
    return m_pos[c] < m_n[c];
  endfunction

  function automatic bit exp_tick(input int c);
    return m_run[c] && (m_pos[c] >= 2 * m_n[c] - 2);
  endfunction

  function automatic void model_posedge();
    bit acc;
    acc = cfg.cfg_valid && m_ready(int'(cfg.cfg_ch));
    for (int c = 0; c < NUM_CH; c++) begin
      bit at_end;
      at_end = !m_run[c] || (m_pos[c] + 1 == 2 * m_n[c]);
      if (m_run[c]) m_pos[c]++;
      if (at_end) begin
        if (m_pend[c]) begin
          m_n[c]    = m_pd[c];
          m_pend[c] = 0;
        end
        m_run[c] = en[c];
        m_pos[c] = 0;
      end
    end
    if (acc) begin
      if (int'(cfg.cfg_div) >= 2 && int'(cfg.cfg_ch) < NUM_CH) begin
        m_pend[cfg.cfg_ch] = 1;
        m_pd[cfg.cfg_ch]   = int'(cfg.cfg_div);
      end else m_err = 1;
    end
  endfunction

  function automatic void model_negedge();
    for (int c = 0; c < NUM_CH; c++)
      if (m_run[c]) m_pos[c]++;
  endfunction

  task automatic check_outs(input string ph);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("%s_div_clk%0d", ph, c), 32'(div_clk[c]), 32'(exp_clk(c)));
      chk($sformatf("%s_tick%0d", ph, c), 32'(tick[c]), 32'(exp_tick(c)));
    end
    chk($sformatf("%s_cfg_err", ph), 32'(cfg.cfg_err), 32'(m_err));
  endtask

  task automatic drive(input bit rnd);
    int r;
    if (!rnd) begin
      cfg.cfg_valid = 1'b0;
      return;
    end
    if ($urandom_range(63) == 0) begin
      r = $urandom_range(NUM_CH - 1);
      en[r] = ~en[r];
    end
    cfg.cfg_valid = ($urandom_range(7) == 0);
    cfg.cfg_ch    = 2'($urandom_range(NUM_CH - 1));
    r = $urandom_range(31);
    if (r < 2)                       cfg.cfg_div = DIV_W'(r);
    else if ($urandom_range(7) == 0) cfg.cfg_div = DIV_W'($urandom_range(255, 2));
    else                             cfg.cfg_div = DIV_W'($urandom_range(9, 2));
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk);
      model_posedge();
      #2 check_outs("pos");
      drive(rnd);
      #1 chk("cfg_ready", 32'(cfg.cfg_ready), 32'(m_ready(int'(cfg.cfg_ch))));
      @(negedge clk);
      model_negedge();
      #2 check_outs("neg");
    end
  endtask

  task automatic cfg_write(input int ch, input int d);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'(ch);
    cfg.cfg_div   = DIV_W'(d);
    run_cycles(1, 0);
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_div   = '0;
    model_reset();

    #35;
    chk("rst_div_clk", 32'(div_clk), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_cfg_err", 32'(cfg.cfg_err), 32'(0));
    chk("rst_cfg_ready", 32'(cfg.cfg_ready), 32'(1));
    #15 rst = 1'b0;

    // Default /2 on all channels, then the legacy /2,/4,/8,/16 set.
    run_cycles(10, 0);
    cfg_write(0, 2);
    cfg_write(1, 4);
    cfg_write(2, 8);
    cfg_write(3, 16);
    run_cycles(100, 0);

    // Odd divisors and a discarded illegal write.
    cfg_write(0, 3);
    cfg_write(1, 5);
    run_cycles(40, 0);
    cfg_write(2, 1);
    run_cycles(20, 0);
    chk("illegal_err_set", 32'(cfg.cfg_err), 32'(1));

    run_cycles(3000, 1);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #7 rst = 1'b1;
    #1;
    chk("midrst_div_clk", 32'(div_clk), 32'(0));
    chk("midrst_tick", 32'(tick), 32'(0));
    chk("midrst_cfg_err", 32'(cfg.cfg_err), 32'(0));
    en = '1;
    cfg.cfg_valid = 1'b0;
    model_reset();
    #40;
    @(negedge clk);
    #2 rst = 1'b0;
    run_cycles(50, 0);
    run_cycles(1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
